// File: rtl/hidden_layer_sequencer.sv
// hidden_layer_sequencer: time-multiplexes one shared neuron datapath across all hidden-layer neurons
module hidden_layer_sequencer #(
  parameter int N_IN     = 10,
  parameter int N_HIDDEN = 8,
  parameter int IN_W     = 10,
  parameter int W_W      = 10,
  parameter int AW       = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*IN_W-1:0]     in_vec,
  output logic                     w_rd_en,
  output logic [AW-1:0]            w_addr,
  input  logic [N_IN*W_W-1:0]      w_rd_data,
  output logic [N_IN*IN_W-1:0]     nrn_in,
  output logic [N_IN*W_W-1:0]      nrn_weight,
  input  logic [IN_W-1:0]          nrn_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_HIDDEN*IN_W-1:0] out_vec,
  output logic                     busy
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, CAPTURE, DONE} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_k;
  logic [N_IN*IN_W-1:0] r_nrn_in;
  logic [N_IN*W_W-1:0] r_nrn_weight;
  logic [N_HIDDEN*IN_W-1:0] r_out_vec;
  logic w_last, w_accept;
  assign w_last   = r_k == AW'(N_HIDDEN - 1);
  assign w_accept = in_valid && r_state == IDLE;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next-state logic: three cycles per neuron, hold in DONE until downstream accepts
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = in_valid ? FETCH : IDLE;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = CAPTURE;
      CAPTURE: w_next = w_last ? DONE : FETCH;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // handshake and ROM strobe decoded from state
  always_comb begin
    in_ready  = r_state == IDLE;
    busy      = r_state != IDLE;
    w_rd_en   = r_state == FETCH;
    out_valid = r_state == DONE;
  end
  // datapath: latch inputs on accept, weights in LOAD, activation into slot k in CAPTURE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k          <= '0;
      r_nrn_in     <= '0;
      r_nrn_weight <= '0;
      r_out_vec    <= '0;
    end else begin
      if (w_accept) begin
        r_nrn_in <= in_vec;
        r_k      <= '0;
      end
      if (r_state == LOAD) r_nrn_weight <= w_rd_data;
      if (r_state == CAPTURE) begin
        r_out_vec[int'(r_k)*IN_W +: IN_W] <= nrn_out;
        if (!w_last) r_k <= r_k + 1'b1;
      end
    end
  end
  // k only changes on accept or when stepping to the next FETCH, so it doubles as the held ROM address
  assign w_addr     = r_k;
  assign nrn_in     = r_nrn_in;
  assign nrn_weight = r_nrn_weight;
  assign out_vec    = r_out_vec;
endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// tb_hidden_layer_sequencer: directed self-checking bench with ROM and neuron stubs
module tb_hidden_layer_sequencer;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0, in_ready, w_rd_en, out_valid, busy;
  logic [99:0] in_vec = '0, w_rd_data, nrn_in, nrn_weight;
  logic [2:0] w_addr;
  logic [9:0] nrn_out;
  logic [79:0] out_vec;
  logic in1_valid = 0, out1_ready = 0, in1_ready, w1_rd_en, out1_valid, busy1;
  logic [99:0] in1_vec = '0, w1_rd_data, nrn1_in, nrn1_weight;
  logic [0:0] w1_addr;
  logic [9:0] nrn1_out, out1_vec;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  hidden_layer_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data), .nrn_in(nrn_in),
    .nrn_weight(nrn_weight), .nrn_out(nrn_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .busy(busy));

  hidden_layer_sequencer #(.N_HIDDEN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .in_vec(in1_vec),
    .w_rd_en(w1_rd_en), .w_addr(w1_addr), .w_rd_data(w1_rd_data), .nrn_in(nrn1_in),
    .nrn_weight(nrn1_weight), .nrn_out(nrn1_out), .out_valid(out1_valid), .out_ready(out1_ready),
    .out_vec(out1_vec), .busy(busy1));

  function automatic logic [99:0] fill(input int v);
    for (int i = 0; i < 10; i++) fill[i*10 +: 10] = 10'(v);
  endfunction

  function automatic logic [9:0] neuron(input logic [99:0] x, input logic [99:0] w);
    int acc = 0;
    for (int i = 0; i < 10; i++) acc += int'(x[i*10 +: 10]) * int'($signed(w[i*10 +: 10]));
    return 10'(acc);
  endfunction

  function automatic logic [79:0] exp_vec(input int v);
    for (int k = 0; k < 8; k++) exp_vec[k*10 +: 10] = 10'(v * 10 * (k + 1));
  endfunction

  always_ff @(posedge clk) if (w_rd_en) w_rd_data <= fill(int'(w_addr) + 1);
  always_ff @(posedge clk) if (w1_rd_en) w1_rd_data <= fill(int'(w1_addr) + 1);
  assign nrn_out  = neuron(nrn_in, nrn_weight);
  assign nrn1_out = neuron(nrn1_in, nrn1_weight);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick;
      n++;
    end
  endtask

  task automatic release_frame;
    out_ready = 1;
    tick;
    check("hs_in_ready", 80'(in_ready), 80'(1));
    check("hs_out_valid", 80'(out_valid), 80'(0));
    out_ready = 0;
  endtask

  initial begin
    int n, nf, na, no;
    int acc[2];
    logic [79:0] ov[2];
    tick;
    tick;
    rst = 0;
    check("rst_in_ready", 80'(in_ready), 80'(1));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_w_rd_en", 80'(w_rd_en), 80'(0));
    check("rst_out_vec", out_vec, 80'(0));
    check("rst_w_addr", 80'(w_addr), 80'(0));
    // frame 1: all-ones inputs, fetch order and latency
    in_vec = fill(1);
    in_valid = 1;
    tick;
    in_valid = 0;
    n = 0;
    nf = 0;
    while (!out_valid && n < 100) begin
      if (w_rd_en) begin
        check("fetch_addr", 80'(w_addr), 80'(nf));
        nf++;
      end
      tick;
      n++;
    end
    check("latency", 80'(n), 80'(24));
    check("fetch_count", 80'(nf), 80'(8));
    check("frame1_vec", out_vec, exp_vec(1));
    // backpressure in DONE
    for (int i = 0; i < 5; i++) tick;
    check("bp_out_valid", 80'(out_valid), 80'(1));
    check("bp_out_vec", out_vec, exp_vec(1));
    check("bp_in_ready", 80'(in_ready), 80'(0));
    release_frame;
    // in_valid during CAPTURE of neuron 3 is ignored
    in_vec = fill(2);
    in_valid = 1;
    tick;
    in_valid = 0;
    for (int i = 0; i < 11; i++) tick;
    in_vec = fill(3);
    in_valid = 1;
    tick;
    in_valid = 0;
    check("ign_nrn_in", 80'(nrn_in), 80'(fill(2)));
    wait_out(n);
    check("ign_latency", 80'(n), 80'(12));
    check("ign_vec", out_vec, exp_vec(2));
    check("ign_nrn_in_end", 80'(nrn_in), 80'(fill(2)));
    release_frame;
    // reset during LOAD of neuron 5
    in_vec = fill(1);
    in_valid = 1;
    tick;
    in_valid = 0;
    for (int i = 0; i < 16; i++) tick;
    check("mid_in_load_k", 80'(w_addr), 80'(5));
    rst = 1;
    tick;
    rst = 0;
    check("mrst_in_ready", 80'(in_ready), 80'(1));
    check("mrst_busy", 80'(busy), 80'(0));
    check("mrst_out_vec", out_vec, 80'(0));
    check("mrst_w_rd_en", 80'(w_rd_en), 80'(0));
    check("mrst_out_valid", 80'(out_valid), 80'(0));
    check("mrst_nrn_in", 80'(nrn_in), 80'(0));
    check("mrst_w_addr", 80'(w_addr), 80'(0));
    in_vec = fill(4);
    in_valid = 1;
    tick;
    in_valid = 0;
    wait_out(n);
    check("post_rst_latency", 80'(n), 80'(24));
    check("post_rst_vec", out_vec, exp_vec(4));
    release_frame;
    // back-to-back frames
    in_vec = fill(1);
    in_valid = 1;
    out_ready = 1;
    na = 0;
    no = 0;
    n = 0;
    while (no < 2 && n < 200) begin
      if (in_ready && na < 2) begin
        acc[na] = n;
        na++;
      end
      if (out_valid) begin
        ov[no] = out_vec;
        no++;
      end
      if (no < 2) begin
        tick;
        n++;
        if (na >= 1) in_vec = fill(5);
      end
    end
    in_valid = 0;
    tick;
    out_ready = 0;
    check("b2b_frames", 80'(no), 80'(2));
    check("b2b_spacing", 80'(acc[1] - acc[0]), 80'(26));
    check("b2b_vec0", ov[0], exp_vec(1));
    check("b2b_vec1", ov[1], exp_vec(5));
    check("b2b_idle", 80'(in_ready), 80'(1));
    // single-neuron instance
    in1_vec = fill(1);
    in1_valid = 1;
    tick;
    in1_valid = 0;
    check("n1_fetch_en", 80'(w1_rd_en), 80'(1));
    check("n1_fetch_addr", 80'(w1_addr), 80'(0));
    n = 0;
    while (!out1_valid && n < 100) begin
      tick;
      n++;
    end
    check("n1_latency", 80'(n), 80'(3));
    check("n1_vec", 80'(out1_vec), 80'(10));
    out1_ready = 1;
    tick;
    out1_ready = 0;
    check("n1_idle", 80'(in1_ready), 80'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
